// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the 5-stage IF/ID/EX/MEM/WB core.
//   fwd_sel_t      : EX operand source select driven by the hazard unit
//   shadow_entry_t : per-stage copy of an in-flight instruction's register usage
//   OP_*           : opcodes the decoder uses to classify loads, stores and branches
package pipe_pkg;

    // Register fields in the shadow entry are sized for the widest register
    // file supported. Narrower files are zero-extended into these fields.
    localparam int MAX_REG_AW = 8;

    typedef enum logic [1:0] {
        FWD_RF    = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_t;

    typedef struct packed {
        logic                  valid;
        logic [MAX_REG_AW-1:0] rs;
        logic [MAX_REG_AW-1:0] rt;
        logic                  use_rs;
        logic                  use_rt;
        logic [MAX_REG_AW-1:0] dst;
        logic                  reg_write;
        logic                  is_load;
    } shadow_entry_t;

    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_SW  = 6'h2b;
    localparam logic [5:0] OP_BEQ = 6'h04;
    localparam logic [5:0] OP_BNE = 6'h05;

    // Turns an entry into a bubble. The payload is left as-is because every
    // consumer qualifies it with valid.
    function automatic shadow_entry_t drop_valid(input shadow_entry_t e);
        shadow_entry_t r;
        r       = e;
        r.valid = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/hazard_match.sv
// Single shadow entry versus single source register comparator.
// Ports:
//   valid_i, reg_write_i : entry holds a live instruction that writes a register
//   dst_i                : entry destination register
//   src_i, use_i         : consumer source register and whether it is read
//   match_o              : consumer depends on this entry's result
module hazard_match #(
    parameter int AW       = 8,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic          valid_i,
    input  logic          reg_write_i,
    input  logic [AW-1:0] dst_i,
    input  logic [AW-1:0] src_i,
    input  logic          use_i,
    output logic          match_o
);

    logic zero_src;

    // With a hardwired-zero register, writes to $0 are discarded, so reading
    // $0 can never depend on an older instruction.
    assign zero_src = ZERO_REG && (src_i == '0);

    assign match_o = valid_i & reg_write_i & use_i & (dst_i == src_i) & ~zero_src;

endmodule

// File: rtl/hazard_fwd_unit.sv
// Hazard detection and forwarding controller for the 5-stage pipeline.
// Tracks a shadow copy of the instructions in EX, MEM and WB and derives
// operand forwarding, load-use / interlock stalls, taken-branch flushes and a
// global freeze while data memory is busy.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   id_valid                 : ID holds a real instruction
//   id_rs, id_rt             : ID source registers; id_use_rs/id_use_rt qualify them
//   id_dst, id_reg_write     : ID destination and write enable
//   id_is_load               : ID instruction is a load
//   br_taken                 : branch in MEM resolved taken
//   mem_busy                 : data memory not ready this cycle
//   pc_we, if_id_we          : PC and IF/ID load enables
//   flush_if_id              : bubble into IF/ID
//   id_ex_bubble             : bubble into ID/EX
//   flush_ex_mem             : bubble into EX/MEM
//   fwd_a, fwd_b             : EX operand selects (0 RF, 1 EX/MEM, 2 MEM/WB)
//   stall_cnt                : saturating count of cycles with pc_we low
module hazard_fwd_unit
    import pipe_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter bit FWD_EN   = 1'b1,
    parameter bit ZERO_REG = 1'b1,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic [REG_AW-1:0] id_dst,
    input  logic              id_reg_write,
    input  logic              id_is_load,
    input  logic              br_taken,
    input  logic              mem_busy,
    output logic              pc_we,
    output logic              if_id_we,
    output logic              flush_if_id,
    output logic              id_ex_bubble,
    output logic              flush_ex_mem,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [CNT_W-1:0]  stall_cnt
);

    shadow_entry_t s_ex_q, s_mem_q, s_wb_q;
    shadow_entry_t s_ex_d, s_mem_d, s_wb_d;
    shadow_entry_t id_entry;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Entry index 0 = S_EX, 1 = S_MEM, 2 = S_WB; source index 0 = rs, 1 = rt.
    logic [2:0]            e_valid;
    logic [2:0]            e_rw;
    logic [MAX_REG_AW-1:0] e_dst [3];
    logic [MAX_REG_AW-1:0] id_src [2];
    logic [1:0]            id_use;
    logic [MAX_REG_AW-1:0] ex_src [2];
    logic [1:0]            ex_use;
    logic [5:0]            id_hit;   // bit e*2+s: entry e feeds ID source s
    logic [3:0]            ex_hit;   // bit (e-1)*2+s: MEM/WB entry feeds EX source s
    logic                  load_use;
    logic                  interlock;
    logic                  hazard;

    function automatic fwd_sel_t fwd_pick(input logic mem_hit, input logic wb_hit);
        // The younger producer in MEM holds the newest value of the register.
        if (mem_hit)     return FWD_EXMEM;
        else if (wb_hit) return FWD_MEMWB;
        else             return FWD_RF;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == '1) return v;
        else         return v + CNT_W'(1);
    endfunction

    always_comb begin
        id_entry           = '0;
        id_entry.valid     = id_valid;
        id_entry.rs        = MAX_REG_AW'(id_rs);
        id_entry.rt        = MAX_REG_AW'(id_rt);
        id_entry.use_rs    = id_use_rs;
        id_entry.use_rt    = id_use_rt;
        id_entry.dst       = MAX_REG_AW'(id_dst);
        id_entry.reg_write = id_reg_write;
        id_entry.is_load   = id_is_load;
    end

    assign e_valid = {s_wb_q.valid, s_mem_q.valid, s_ex_q.valid};
    assign e_rw    = {s_wb_q.reg_write, s_mem_q.reg_write, s_ex_q.reg_write};
    assign e_dst[0] = s_ex_q.dst;
    assign e_dst[1] = s_mem_q.dst;
    assign e_dst[2] = s_wb_q.dst;

    assign id_src[0] = id_entry.rs;
    assign id_src[1] = id_entry.rt;
    assign id_use    = {id_valid & id_use_rt, id_valid & id_use_rs};

    // A bubble sitting in EX has no operands to forward.
    assign ex_src[0] = s_ex_q.rs;
    assign ex_src[1] = s_ex_q.rt;
    assign ex_use    = {s_ex_q.valid & s_ex_q.use_rt, s_ex_q.valid & s_ex_q.use_rs};

    for (genvar s = 0; s < 2; s++) begin : g_src
        for (genvar e = 0; e < 3; e++) begin : g_id
            hazard_match #(.AW(MAX_REG_AW), .ZERO_REG(ZERO_REG)) u_id_match (
                .valid_i     (e_valid[e]),
                .reg_write_i (e_rw[e]),
                .dst_i       (e_dst[e]),
                .src_i       (id_src[s]),
                .use_i       (id_use[s]),
                .match_o     (id_hit[e*2+s])
            );
        end
        for (genvar e = 1; e < 3; e++) begin : g_ex
            hazard_match #(.AW(MAX_REG_AW), .ZERO_REG(ZERO_REG)) u_ex_match (
                .valid_i     (e_valid[e]),
                .reg_write_i (e_rw[e]),
                .dst_i       (e_dst[e]),
                .src_i       (ex_src[s]),
                .use_i       (ex_use[s]),
                .match_o     (ex_hit[(e-1)*2+s])
            );
        end
    end

    assign load_use  = s_ex_q.is_load & (id_hit[0] | id_hit[1]);
    // Without forwarding the consumer waits until the producer has left WB,
    // since the register file does not pass a same-cycle write to the read.
    assign interlock = |id_hit;
    assign hazard    = FWD_EN ? load_use : interlock;

    always_comb begin
        pc_we        = 1'b1;
        if_id_we     = 1'b1;
        flush_if_id  = 1'b0;
        id_ex_bubble = 1'b0;
        flush_ex_mem = 1'b0;
        fwd_a        = FWD_RF;
        fwd_b        = FWD_RF;
        if (rst) begin
            pc_we        = 1'b0;
            if_id_we     = 1'b0;
            flush_if_id  = 1'b1;
            id_ex_bubble = 1'b1;
            flush_ex_mem = 1'b1;
        end else if (mem_busy) begin
            pc_we    = 1'b0;
            if_id_we = 1'b0;
        end else if (br_taken) begin
            // Flush wins over a coincident stall so the branch target loads.
            flush_if_id  = 1'b1;
            id_ex_bubble = 1'b1;
            flush_ex_mem = 1'b1;
        end else if (hazard) begin
            pc_we        = 1'b0;
            if_id_we     = 1'b0;
            id_ex_bubble = 1'b1;
        end
        if (!rst && FWD_EN) begin
            fwd_a = fwd_pick(ex_hit[0], ex_hit[2]);
            fwd_b = fwd_pick(ex_hit[1], ex_hit[3]);
        end
    end

    always_comb begin
        s_ex_d  = s_ex_q;
        s_mem_d = s_mem_q;
        s_wb_d  = s_wb_q;
        if (!mem_busy) begin
            s_wb_d = s_mem_q;
            if (br_taken) begin
                s_mem_d = drop_valid(s_ex_q);
                s_ex_d  = drop_valid(id_entry);
            end else begin
                s_mem_d = s_ex_q;
                s_ex_d  = hazard ? drop_valid(id_entry) : id_entry;
            end
        end
        cnt_d = pc_we ? cnt_q : sat_inc(cnt_q);
    end

    // ---- shadow EX/MEM/WB registers and stall counter ----
    always_ff @(posedge clk) begin
        if (rst) begin
            s_ex_q.valid  <= 1'b0;
            s_mem_q.valid <= 1'b0;
            s_wb_q.valid  <= 1'b0;
            cnt_q         <= '0;
        end else begin
            s_ex_q  <= s_ex_d;
            s_mem_q <= s_mem_d;
            s_wb_q  <= s_wb_d;
            cnt_q   <= cnt_d;
        end
    end

    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
module tb_hazard_fwd_unit;

    // Three configurations share one stimulus stream:
    //   0: forwarding, $0 ignored, 16-bit counter
    //   1: interlock only, $0 ignored, 16-bit counter
    //   2: forwarding, $0 treated as ordinary register, 3-bit counter
    localparam bit CFG_FWD [3] = '{1'b1, 1'b0, 1'b1};
    localparam bit CFG_ZR  [3] = '{1'b1, 1'b1, 1'b0};
    localparam int CFG_MAX [3] = '{65535, 65535, 7};

    logic clk;
    logic rst, id_valid, id_use_rs, id_use_rt, id_reg_write, id_is_load;
    logic br_taken, mem_busy;
    logic [4:0] id_rs, id_rt, id_dst;

    logic pc_we_w [3];
    logic if_id_we_w [3];
    logic fl_ifid_w [3];
    logic bub_w [3];
    logic fl_exmem_w [3];
    logic [1:0] fa_w [3];
    logic [1:0] fb_w [3];
    logic [15:0] cnt0, cnt1;
    logic [2:0]  cnt2;

    hazard_fwd_unit #(.REG_AW(5), .FWD_EN(1'b1), .ZERO_REG(1'b1), .CNT_W(16)) u_dut0 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dst(id_dst),
        .id_reg_write(id_reg_write), .id_is_load(id_is_load), .br_taken(br_taken),
        .mem_busy(mem_busy), .pc_we(pc_we_w[0]), .if_id_we(if_id_we_w[0]),
        .flush_if_id(fl_ifid_w[0]), .id_ex_bubble(bub_w[0]), .flush_ex_mem(fl_exmem_w[0]),
        .fwd_a(fa_w[0]), .fwd_b(fb_w[0]), .stall_cnt(cnt0));

    hazard_fwd_unit #(.REG_AW(5), .FWD_EN(1'b0), .ZERO_REG(1'b1), .CNT_W(16)) u_dut1 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dst(id_dst),
        .id_reg_write(id_reg_write), .id_is_load(id_is_load), .br_taken(br_taken),
        .mem_busy(mem_busy), .pc_we(pc_we_w[1]), .if_id_we(if_id_we_w[1]),
        .flush_if_id(fl_ifid_w[1]), .id_ex_bubble(bub_w[1]), .flush_ex_mem(fl_exmem_w[1]),
        .fwd_a(fa_w[1]), .fwd_b(fb_w[1]), .stall_cnt(cnt1));

    hazard_fwd_unit #(.REG_AW(5), .FWD_EN(1'b1), .ZERO_REG(1'b0), .CNT_W(3)) u_dut2 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dst(id_dst),
        .id_reg_write(id_reg_write), .id_is_load(id_is_load), .br_taken(br_taken),
        .mem_busy(mem_busy), .pc_we(pc_we_w[2]), .if_id_we(if_id_we_w[2]),
        .flush_if_id(fl_ifid_w[2]), .id_ex_bubble(bub_w[2]), .flush_ex_mem(fl_exmem_w[2]),
        .fwd_a(fa_w[2]), .fwd_b(fb_w[2]), .stall_cnt(cnt2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the three in-flight instructions per configuration.
    typedef struct {
        bit v;
        int rs, rt, dst;
        bit urs, urt, rw, ld;
    } ins_t;

    ins_t m_ex [3];
    ins_t m_mem [3];
    ins_t m_wb [3];
    int   m_cnt [3];
    bit   e_pc [3];
    bit   e_stall [3];
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic ins_t cur_ins();
        ins_t r;
        r.v = id_valid; r.rs = id_rs; r.rt = id_rt; r.dst = id_dst;
        r.urs = id_use_rs; r.urt = id_use_rt; r.rw = id_reg_write; r.ld = id_is_load;
        return r;
    endfunction

    // Does instruction x produce a value that a reader of register s needs?
    function automatic bit feeds(ins_t x, int s, bit used, int c);
        return x.v && x.rw && used && x.dst == s && !(CFG_ZR[c] && s == 0);
    endfunction

    function automatic bit stall_exp(int c, ins_t id);
        bit dep_ex, dep_mem, dep_wb;
        if (!id.v) return 1'b0;
        dep_ex  = feeds(m_ex[c], id.rs, id.urs, c)  || feeds(m_ex[c], id.rt, id.urt, c);
        dep_mem = feeds(m_mem[c], id.rs, id.urs, c) || feeds(m_mem[c], id.rt, id.urt, c);
        dep_wb  = feeds(m_wb[c], id.rs, id.urs, c)  || feeds(m_wb[c], id.rt, id.urt, c);
        if (CFG_FWD[c]) return m_ex[c].ld && dep_ex;
        return dep_ex || dep_mem || dep_wb;
    endfunction

    function automatic int fwd_exp(int c, bit opa);
        int s;
        bit u;
        if (rst || !CFG_FWD[c] || !m_ex[c].v) return 0;
        s = opa ? m_ex[c].rs : m_ex[c].rt;
        u = opa ? m_ex[c].urs : m_ex[c].urt;
        if (feeds(m_mem[c], s, u, c)) return 1;
        if (feeds(m_wb[c], s, u, c))  return 2;
        return 0;
    endfunction

    function automatic int dut_cnt(int c);
        case (c)
            0:       return int'(cnt0);
            1:       return int'(cnt1);
            default: return int'(cnt2);
        endcase
    endfunction

    task automatic check_cycle();
        ins_t id;
        bit pc, ifid, fl, bub, fem;
        #1;
        id = cur_ins();
        for (int c = 0; c < 3; c++) begin
            e_stall[c] = stall_exp(c, id);
            pc = 1; ifid = 1; fl = 0; bub = 0; fem = 0;
            if (rst) begin
                pc = 0; ifid = 0; fl = 1; bub = 1; fem = 1;
            end else if (mem_busy) begin
                pc = 0; ifid = 0;
            end else if (br_taken) begin
                fl = 1; bub = 1; fem = 1;
            end else if (e_stall[c]) begin
                pc = 0; ifid = 0; bub = 1;
            end
            e_pc[c] = pc;
            check_eq($sformatf("c%0d_pc_we", c), int'(pc_we_w[c]), int'(pc));
            check_eq($sformatf("c%0d_if_id_we", c), int'(if_id_we_w[c]), int'(ifid));
            check_eq($sformatf("c%0d_flush_if_id", c), int'(fl_ifid_w[c]), int'(fl));
            check_eq($sformatf("c%0d_id_ex_bubble", c), int'(bub_w[c]), int'(bub));
            check_eq($sformatf("c%0d_flush_ex_mem", c), int'(fl_exmem_w[c]), int'(fem));
            check_eq($sformatf("c%0d_fwd_a", c), int'(fa_w[c]), fwd_exp(c, 1'b1));
            check_eq($sformatf("c%0d_fwd_b", c), int'(fb_w[c]), fwd_exp(c, 1'b0));
            check_eq($sformatf("c%0d_stall_cnt", c), dut_cnt(c), m_cnt[c]);
        end
    endtask

    task automatic next_cycle();
        ins_t id;
        id = cur_ins();
        for (int c = 0; c < 3; c++) begin
            if (rst) begin
                m_ex[c].v = 0; m_mem[c].v = 0; m_wb[c].v = 0; m_cnt[c] = 0;
            end else begin
                if (!e_pc[c] && m_cnt[c] < CFG_MAX[c]) m_cnt[c]++;
                if (!mem_busy) begin
                    m_wb[c] = m_mem[c];
                    if (br_taken) begin
                        m_mem[c].v = 0;
                        m_ex[c].v  = 0;
                    end else begin
                        m_mem[c] = m_ex[c];
                        m_ex[c]  = id;
                        if (e_stall[c]) m_ex[c].v = 0;
                    end
                end
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic set_id(input bit v, input int rs, input bit urs, input int rt,
                          input bit urt, input int dst, input bit rw, input bit ld);
        id_valid = v; id_rs = 5'(rs); id_use_rs = urs; id_rt = 5'(rt); id_use_rt = urt;
        id_dst = 5'(dst); id_reg_write = rw; id_is_load = ld;
    endtask

    task automatic idle();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        rst = 1; idle(); check_cycle(); next_cycle(); rst = 0;
    endtask

    initial begin
        for (int c = 0; c < 3; c++) begin
            m_ex[c] = '{default: 0}; m_mem[c] = '{default: 0}; m_wb[c] = '{default: 0};
            m_cnt[c] = 0;
        end
        rst = 1; br_taken = 0; mem_busy = 0; idle();
        @(negedge clk);

        // Reset cycle and first cycle after reset
        rst = 1; check_cycle();
        check_eq("rst_pc_we", int'(pc_we_w[0]), 0);
        check_eq("rst_flush_if_id", int'(fl_ifid_w[0]), 1);
        check_eq("rst_bubble", int'(bub_w[0]), 1);
        check_eq("rst_flush_ex_mem", int'(fl_exmem_w[0]), 1);
        next_cycle();
        rst = 0; check_cycle();
        check_eq("post_rst_pc_we", int'(pc_we_w[0]), 1);
        check_eq("post_rst_flush", int'(fl_ifid_w[0]), 0);
        check_eq("post_rst_cnt", int'(cnt0), 0);
        next_cycle();

        // add $3,$1,$2 ; sub $4,$3,$1 -> EX/MEM forward
        set_id(1, 1, 1, 2, 1, 3, 1, 0); check_cycle(); next_cycle();
        set_id(1, 3, 1, 1, 1, 4, 1, 0); check_cycle();
        check_eq("exmem_no_stall", int'(pc_we_w[0]), 1);
        next_cycle();
        idle(); check_cycle();
        check_eq("fwd_exmem", int'(fa_w[0]), 1);
        next_cycle();

        // add $3 ; unrelated ; sub $4,$3,$1 -> MEM/WB forward
        set_id(1, 1, 1, 2, 1, 3, 1, 0); check_cycle(); next_cycle();
        set_id(1, 7, 1, 7, 1, 9, 1, 0); check_cycle(); next_cycle();
        set_id(1, 3, 1, 1, 1, 4, 1, 0); check_cycle(); next_cycle();
        idle(); check_cycle();
        check_eq("fwd_memwb", int'(fa_w[0]), 2);
        next_cycle();

        // lw $5,0($0) ; add $6,$5,$5 -> one stall, then MEM/WB forward
        do_reset();
        set_id(1, 0, 1, 0, 0, 5, 1, 1); check_cycle(); next_cycle();
        set_id(1, 5, 1, 5, 1, 6, 1, 0); check_cycle();
        check_eq("lu_pc_we", int'(pc_we_w[0]), 0);
        check_eq("lu_if_id_we", int'(if_id_we_w[0]), 0);
        check_eq("lu_bubble", int'(bub_w[0]), 1);
        next_cycle();
        check_cycle();
        check_eq("lu_release_pc_we", int'(pc_we_w[0]), 1);
        next_cycle();
        idle(); check_cycle();
        check_eq("lu_fwd_a", int'(fa_w[0]), 2);
        check_eq("lu_fwd_b", int'(fb_w[0]), 2);
        check_eq("lu_stall_cnt", int'(cnt0), 1);
        next_cycle();

        // addi $0,$0,7 ; add $1,$0,$0 -> no forward unless $0 is ordinary
        set_id(1, 0, 1, 0, 0, 0, 1, 0); check_cycle(); next_cycle();
        set_id(1, 0, 1, 0, 1, 1, 1, 0); check_cycle();
        check_eq("zr_no_stall", int'(pc_we_w[0]), 1);
        next_cycle();
        idle(); check_cycle();
        check_eq("zr_fwd_a", int'(fa_w[0]), 0);
        check_eq("zr_fwd_b", int'(fb_w[0]), 0);
        check_eq("nzr_fwd_a", int'(fa_w[2]), 1);
        check_eq("nzr_fwd_b", int'(fb_w[2]), 1);
        next_cycle();

        // Taken branch coinciding with a load-use stall
        set_id(1, 0, 1, 0, 0, 7, 1, 1); check_cycle(); next_cycle();
        set_id(1, 7, 1, 7, 1, 8, 1, 0); br_taken = 1; check_cycle();
        check_eq("br_pc_we", int'(pc_we_w[0]), 1);
        check_eq("br_if_id_we", int'(if_id_we_w[0]), 1);
        check_eq("br_flush_if_id", int'(fl_ifid_w[0]), 1);
        check_eq("br_bubble", int'(bub_w[0]), 1);
        check_eq("br_flush_ex_mem", int'(fl_exmem_w[0]), 1);
        next_cycle();
        br_taken = 0; idle(); check_cycle();
        check_eq("br_fwd_a", int'(fa_w[0]), 0);
        check_eq("br_fwd_b", int'(fb_w[0]), 0);
        next_cycle();

        // Memory wait for 3 cycles with a pending taken branch
        br_taken = 1; mem_busy = 1; set_id(1, 1, 1, 2, 1, 3, 1, 0);
        for (int k = 0; k < 3; k++) begin
            check_cycle();
            check_eq("mw_pc_we", int'(pc_we_w[0]), 0);
            check_eq("mw_flush_if_id", int'(fl_ifid_w[0]), 0);
            check_eq("mw_bubble", int'(bub_w[0]), 0);
            check_eq("mw_flush_ex_mem", int'(fl_exmem_w[0]), 0);
            next_cycle();
        end
        mem_busy = 0; check_cycle();
        check_eq("mw_release_flush", int'(fl_ifid_w[0]), 1);
        check_eq("mw_stall_cnt", int'(cnt0), 4);
        next_cycle();
        br_taken = 0;

        // Interlock-only: add $3 then a held $3 consumer
        do_reset();
        set_id(1, 1, 1, 2, 1, 3, 1, 0); check_cycle(); next_cycle();
        set_id(1, 3, 1, 1, 1, 4, 1, 0);
        for (int k = 0; k < 4; k++) begin
            check_cycle();
            check_eq($sformatf("il_pc_we_%0d", k), int'(pc_we_w[1]), (k == 3) ? 1 : 0);
            next_cycle();
        end

        // Reset in the middle of an interlock
        set_id(1, 1, 1, 2, 1, 3, 1, 0); check_cycle(); next_cycle();
        set_id(1, 3, 1, 1, 1, 4, 1, 0); check_cycle();
        check_eq("il_mid_pc_we", int'(pc_we_w[1]), 0);
        next_cycle();
        rst = 1; check_cycle();
        check_eq("il_rst_pc_we", int'(pc_we_w[1]), 0);
        check_eq("il_rst_flush", int'(fl_ifid_w[1]), 1);
        check_eq("il_rst_bubble", int'(bub_w[1]), 1);
        next_cycle();
        rst = 0; check_cycle();
        check_eq("il_after_rst_pc_we", int'(pc_we_w[1]), 1);
        check_eq("il_after_rst_cnt", int'(cnt1), 0);
        next_cycle();

        // Counter saturation: 10 frozen cycles
        do_reset();
        mem_busy = 1; idle();
        for (int k = 0; k < 10; k++) begin
            check_cycle(); next_cycle();
        end
        mem_busy = 0; check_cycle();
        check_eq("sat_cnt3", int'(cnt2), 7);
        check_eq("sat_cnt16", int'(cnt0), 10);
        next_cycle();

        // Randomized traffic against the model
        for (int k = 0; k < 2000; k++) begin
            rst      = ($urandom_range(0, 63) == 0);
            mem_busy = ($urandom_range(0, 5) == 0);
            br_taken = ($urandom_range(0, 7) == 0);
            set_id($urandom_range(0, 7) != 0,
                   $urandom_range(0, 3), $urandom_range(0, 5) != 0,
                   $urandom_range(0, 3), $urandom_range(0, 3) != 0,
                   $urandom_range(0, 3), $urandom_range(0, 3) != 0,
                   $urandom_range(0, 2) == 0);
            check_cycle();
            next_cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
